// File: rtl/shift_rows_serial.sv
// Byte-serial AES ShiftRows with ping-pong 16-byte banks, 1 byte/cycle in and out.
// Optional SHIFT_ROWS_INV_EN adds inv_in to select the inverse permutation per state.
module shift_rows_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last
`ifdef SHIFT_ROWS_INV_EN
    ,
    input  logic       inv_in
`endif
);

    logic [3:0] wr_cnt_q, wr_cnt_d;
    logic [3:0] rd_cnt_q, rd_cnt_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] full_q, full_d;
    logic [7:0] mem_q [0:1][0:15];
    logic [7:0] mem_d [0:1][0:15];
`ifdef SHIFT_ROWS_INV_EN
    logic [1:0] mode_q, mode_d;
`endif

    logic       wr_fire;
    logic       rd_fire;
    logic [3:0] rd_src;

    // Index is {column, row}; 2-bit column arithmetic gives the mod-4 rotation for free.
    function automatic logic [3:0] fwd_src(input logic [3:0] k);
        return {k[3:2] + k[1:0], k[1:0]};
    endfunction

    function automatic logic [3:0] inv_src(input logic [3:0] k);
        return {k[3:2] - k[1:0], k[1:0]};
    endfunction

    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign out_last  = out_valid && (rd_cnt_q == 4'd15);
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;

    always_comb begin
        rd_src = fwd_src(rd_cnt_q);
`ifdef SHIFT_ROWS_INV_EN
        if (mode_q[rd_bank_q]) begin
            rd_src = inv_src(rd_cnt_q);
        end
`endif
    end

    assign out_data = mem_q[rd_bank_q][rd_src];

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        mem_d     = mem_q;
`ifdef SHIFT_ROWS_INV_EN
        mode_d    = mode_q;
`endif

        // Write and read always target different banks, so both updates can land together.
        if (wr_fire) begin
            mem_d[wr_bank_q][wr_cnt_q] = in_data;
`ifdef SHIFT_ROWS_INV_EN
            if (wr_cnt_q == 4'd0) begin
                mode_d[wr_bank_q] = inv_in;
            end
`endif
            wr_cnt_d = wr_cnt_q + 4'd1;
            if (wr_cnt_q == 4'd15) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        if (rd_fire) begin
            rd_cnt_d = rd_cnt_q + 4'd1;
            if (rd_cnt_q == 4'd15) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q  <= 4'd0;
            rd_cnt_q  <= 4'd0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
`ifdef SHIFT_ROWS_INV_EN
            mode_q    <= 2'b00;
`endif
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
`ifdef SHIFT_ROWS_INV_EN
            mode_q    <= mode_d;
`endif
        end
    end

    // Bank storage is never reset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: doc/shift_rows_serial.md
# shift_rows_serial

Byte-serial AES ShiftRows engine for the encryption datapath, the forward counterpart of the inverse-ShiftRows stage used in decryption. It accepts 16-byte AES states one byte per cycle over a valid/ready stream and emits the row-shifted state one byte per cycle over a second valid/ready stream. Two internal 16-byte banks (ping-pong) let the next state load while the current one drains, for a sustained 1 byte/cycle.

## Interface
- Parameters: none; state size (16 bytes) and permutation are fixed by AES.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data holds a valid byte
- in_ready  output  1  block can accept a byte this cycle
- in_data  input  8  state byte, column-major order (byte 0 = state bits [127:120])
- out_valid  output  1  out_data holds a valid byte
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  8  shifted state byte, column-major order
- out_last  output  1  high with the 16th output byte of a state
- inv_in  input  1  (only with SHIFT_ROWS_INV_EN) 1 = inverse permutation for this state

## Operation
- Input byte k (0..15) maps to row r = k%4, column c = k/4.
- Forward: output byte k = input byte r + 4*((c+r)%4). The source sequence is 0,5,10,15, 4,9,14,3, 8,13,2,7, 12,1,6,11.
- Inverse (macro only): output byte k = input byte r + 4*((c-r+4)%4). The source sequence is 0,13,10,7, 4,1,14,11, 8,5,2,15, 12,9,6,3.
- Write side: a 4-bit write counter and a write-bank pointer. Each accepted byte (in_valid && in_ready) is stored at bank[wr_bank][wr_cnt], and wr_cnt increments.
  - On the byte with wr_cnt=15, the bank's full flag sets, wr_cnt wraps to 0 and wr_bank toggles.
- Read side: a 4-bit read counter and a read-bank pointer.
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank][perm(rd_cnt)], a combinational mux from the stored bank.
  - out_last = out_valid && rd_cnt==15.
  - Each transfer (out_valid && out_ready) increments rd_cnt. On rd_cnt=15 the bank's full flag clears, rd_cnt wraps to 0 and rd_bank toggles.
- in_ready = !full[wr_bank]. A partially filled bank always accepts bytes.
- Simultaneous events:
  - Setting full on one bank and clearing full on the other in the same cycle are both performed.
  - A write to the bank being read cannot occur, because full blocks it.
- Downstream stall (out_ready=0): out_data and out_last hold stable while out_valid=1.
- Reset (synchronous, any time, including mid-state):
  - Discards partial and complete states.
  - Clears both full flags, both counters and both pointers.
  - Reset output values: out_valid=0, out_last=0, in_ready=1. out_data is don't-care while out_valid=0 (bank contents are not cleared).

## Timing
- Latency: the first output byte is valid in the cycle after the 16th input byte is accepted.
- Throughput: 1 byte/cycle sustained with in_valid and out_ready held high (no bubbles between states).
- With out_ready=0, the block accepts at most 32 bytes (both banks full), then in_ready=0.
- in_ready and out_valid are derived from registered state only. There is no combinational path from out_ready to in_ready or from in_valid to out_valid.

## Configuration
- SHIFT_ROWS_INV_EN defined:
  - Adds the inv_in port and a 1-bit mode register per bank.
  - inv_in is captured when byte 0 of a state is accepted and selects the forward or inverse sequence for that state's output.
  - Reset clears both mode registers to 0 (forward).
- Undefined: there is no inv_in port and the forward permutation is hard-wired.

## Test plan
- Forward FIPS-197 round 1 state: stream d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> out d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5, out_last only on e5, first out_valid one cycle after 30 is accepted.
- Forward streaming: input 87EC4A8CF26EC3D84D4C46959790E7A6 followed back-to-back by d42711aee0bf98f1b8b45de51e415230, out_ready=1 -> outputs 876E46A6F24CE78C4D904AD897ECC395 then d4bf5d30e0b452aeb84111f11e2798e5, with 32 consecutive out_valid cycles and no input stall.
- Backpressure: out_ready=0, push 3 states -> in_ready drops after byte 32. Raise out_ready -> the 3rd state loads as bank 0 drains, and all bytes arrive in order.
- Reset mid-state: push 7 bytes, assert rst 1 cycle -> out_valid=0, in_ready=1. The next 16 bytes form a clean state with correct output.
- Random valid/ready toggling on both sides over 200 states, checked against a reference permutation model -> zero mismatches, and out_data stable while stalled.
- (SHIFT_ROWS_INV_EN) inv_in=1 with input 876E46A6F24CE78C4D904AD897ECC395 -> 87EC4A8CF26EC3D84D4C46959790E7A6. The next state with inv_in=0 is forward-shifted.
